scoreboard_ctrl: RTL and testbench
==================================

Name: scoreboard_ctrl

Overview:
- Single-clock controller for a two-team scoreboard (home/guest), each score 0..MAX_SCORE.
- Takes four asynchronous push-button inputs (home up/down, guest up/down) and synchronises and edge-detects them.
- Arbitrates the resulting events onto one shared score-update path: at most one score changes per clock.
- Sits between the board's button pins and the 7-segment/display logic; replaces the per-button clocked up/down counters with one synchronous datapath.

Parameters:
- BW, 7, width of each score output (must hold MAX_SCORE).
- MAX_SCORE, 99, upper saturation limit for both scores.
- WIN_SCORE, 21, score that ends the game (only used with SCORE_WIN_EN).

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  asynchronous, active-high reset.
- home_up_i  in  1  async button, home +1.
- home_down_i  in  1  async button, home -1.
- guest_up_i  in  1  async button, guest +1.
- guest_down_i  in  1  async button, guest -1.
- clear_i  in  1  synchronous game clear, level-sensitive, already synchronous to clk_i.
- home_score_o  out  BW  current home score.
- guest_score_o  out  BW  current guest score.
- update_o  out  1  one-cycle pulse in the cycle after any score changed.
- last_team_o  out  1  team of the last applied update (0 = home, 1 = guest).

Behaviour:
- Reset (async assert, sync-to-clock release):
  - Both scores 0; update_o 0; last_team_o 0.
  - All synchroniser, edge and pending flops 0; round-robin pointer = home.
- Input path, per button:
  - 2-FF synchroniser (s1, s2), then history flop s3; event = s2 & ~s3 (rising edge only).
  - Event registers into that button's pending flag on the next clock.
  - Button high first sampled at edge k → pending set at k+2 → score updated at k+3 if granted. Minimum latency 3 clocks.
- Pending flags:
  - One flag per button; a new edge on an already-set flag is merged (not counted twice).
  - Same team has both up and down pending in the same cycle → both flags cleared, no score change, no update_o.
- Arbitration (one grant per clock):
  - Only one team has an actionable pending → that team is granted.
  - Both teams pending → grant the team NOT recorded in the round-robin pointer; the pointer then records the granted team.
  - First contention after reset grants guest (pointer starts at home).
  - Ungranted pending flags are held, never dropped.
  - The granted flag clears in the same clock the score is written.
- Arithmetic:
  - Up at MAX_SCORE, or down at 0 → score unchanged, flag cleared, update_o stays 0, pointer unchanged.
  - No wrap-around ever.
- update_o / last_team_o:
  - update_o is registered, high exactly one clock after each real score change.
  - last_team_o updates together with update_o.
- clear_i: highest priority.
  - While high: both scores forced to 0; all pending flags cleared; pointer reset to home; update_o 0.
  - Edges detected during clear are discarded.
  - Synchroniser flops keep running so a held button does not generate an event on clear release.
- FSM: RUN (normal), CLR (clear_i high). With SCORE_WIN_EN, also OVER.
  - RUN → CLR on clear_i; CLR → RUN when clear_i is low.

Optional Feature:
- Macro: SCORE_WIN_EN.
- Defined:
  - A granted up that makes a score equal WIN_SCORE moves the FSM to OVER.
  - In OVER, all events are discarded and scores are frozen; only clear_i (→ CLR → RUN) or rst_i leaves OVER.
  - Adds output game_over_o (1 bit, high in OVER, reset 0).
- Undefined:
  - No OVER state, no game_over_o port; scores saturate only at MAX_SCORE.

Test Plan:
- Reset: rst_i pulse mid-count with home = 5 → immediately home_score_o = 0, guest_score_o = 0, update_o = 0, no clock needed.
- Latency: home_up_i high 10 clks → home = 1 exactly 3 clks after first sampling edge; update_o one pulse; a held button gives no further increment.
- Saturation: 100 separate guest_up pulses → guest = 99, update_o pulsed 99 times; guest_down at 0 → stays 0, no update_o.
- Contention: home_up_i and guest_up_i rise on the same clock from 0/0 → guest = 1 first (last_team_o = 1), home = 1 the next clock; both applied, none lost.
- Cancel: home_up_i and home_down_i rise together with home = 4 → home stays 4, no update_o.
- Clear and win: home = 20, clear_i high 2 clks → 0/0. With SCORE_WIN_EN: 21 home_up pulses → game_over_o = 1; further guest_up ignored; clear_i returns to RUN with 0/0.

Source files
------------

// File: rtl/scoreboard_ctrl.sv
// scoreboard_ctrl: two-team scoreboard; synchronised, edge-detected buttons share one score-update path.
// Optional macro SCORE_WIN_EN adds the OVER state (game ends at WIN_SCORE) and the game_over_o output.
module scoreboard_ctrl #(
  parameter int BW        = 7,
  parameter int MAX_SCORE = 99,
  parameter int WIN_SCORE = 21
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          home_up_i,
  input  logic          home_down_i,
  input  logic          guest_up_i,
  input  logic          guest_down_i,
  input  logic          clear_i,
  output logic [BW-1:0] home_score_o,
  output logic [BW-1:0] guest_score_o,
  output logic          update_o,
`ifdef SCORE_WIN_EN
  output logic          last_team_o,
  output logic          game_over_o
`else
  output logic          last_team_o
`endif
);

  localparam logic [BW-1:0] LP_MAX = BW'(MAX_SCORE);
  localparam logic [BW-1:0] LP_ONE = BW'(1);

  if (MAX_SCORE >= (1 << BW) || WIN_SCORE > MAX_SCORE || WIN_SCORE < 1) begin : g_paramCheck
    $error("scoreboard_ctrl: MAX_SCORE must fit in BW bits and 1 <= WIN_SCORE <= MAX_SCORE");
  end

  typedef enum logic [1:0] {ST_RUN, ST_CLR, ST_OVER} state_t;

  state_t        r_state;
  state_t        w_nextState;
  logic [3:0]    w_btn;
  logic [3:0]    r_s1;
  logic [3:0]    r_s2;
  logic [3:0]    r_s3;
  logic [3:0]    r_pend;
  logic [3:0]    w_evt;
  logic [3:0]    w_pendNext;
  logic [BW-1:0] r_homeScore;
  logic [BW-1:0] r_guestScore;
  logic          r_ptr;
  logic          r_update;
  logic          r_lastTeam;
  logic          w_accept;
  logic          w_gameOver;
  logic          w_win;
  logic          w_homeUpOk;
  logic          w_homeDnOk;
  logic          w_guestUpOk;
  logic          w_guestDnOk;
  logic          w_homeAct;
  logic          w_guestAct;
  logic          w_grantHome;
  logic          w_grantGuest;

  // Bit order: 0 home up, 1 home down, 2 guest up, 3 guest down.
  assign w_btn = {guest_down_i, guest_up_i, home_down_i, home_up_i};
  assign w_evt = r_s2 & ~r_s3;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_s1 <= '0;
      r_s2 <= '0;
      r_s3 <= '0;
    end else begin
      r_s1 <= w_btn;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  // A team is actionable only with exactly one direction pending and room to move.
  assign w_homeUpOk  = r_pend[0] & ~r_pend[1] & (r_homeScore != LP_MAX);
  assign w_homeDnOk  = r_pend[1] & ~r_pend[0] & (r_homeScore != '0);
  assign w_guestUpOk = r_pend[2] & ~r_pend[3] & (r_guestScore != LP_MAX);
  assign w_guestDnOk = r_pend[3] & ~r_pend[2] & (r_guestScore != '0);
  assign w_homeAct   = w_homeUpOk | w_homeDnOk;
  assign w_guestAct  = w_guestUpOk | w_guestDnOk;

  assign w_grantHome  = w_homeAct & (~w_guestAct | r_ptr);
  assign w_grantGuest = w_guestAct & (~w_homeAct | ~r_ptr);

  // Only an actionable, ungranted team keeps its flags; cancels and no-op requests drop here.
  assign w_pendNext[1:0] = ({2{w_homeAct & ~w_grantHome}} & r_pend[1:0]) | w_evt[1:0];
  assign w_pendNext[3:2] = ({2{w_guestAct & ~w_grantGuest}} & r_pend[3:2]) | w_evt[3:2];

`ifdef SCORE_WIN_EN
  localparam logic [BW-1:0] LP_WIN = BW'(WIN_SCORE);
  assign w_win = (w_grantHome & w_homeUpOk & ((r_homeScore + LP_ONE) == LP_WIN)) |
                 (w_grantGuest & w_guestUpOk & ((r_guestScore + LP_ONE) == LP_WIN));
  assign game_over_o = w_gameOver;
`else
  assign w_win = 1'b0;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    unique case (r_state)
      ST_RUN:  if (clear_i) w_nextState = ST_CLR;
               else if (w_win) w_nextState = ST_OVER;
      ST_CLR:  if (!clear_i) w_nextState = w_win ? ST_OVER : ST_RUN;
      ST_OVER: if (clear_i) w_nextState = ST_CLR;
      default: w_nextState = ST_RUN;
    endcase
  end

  always_comb begin
    w_gameOver = (r_state == ST_OVER);
    w_accept   = ~clear_i & ~w_gameOver;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_pend       <= '0;
      r_homeScore  <= '0;
      r_guestScore <= '0;
      r_ptr        <= 1'b0;
      r_update     <= 1'b0;
      r_lastTeam   <= 1'b0;
    end else if (clear_i) begin
      r_pend       <= '0;
      r_homeScore  <= '0;
      r_guestScore <= '0;
      r_ptr        <= 1'b0;
      r_update     <= 1'b0;
    end else if (!w_accept) begin
      r_pend   <= '0;
      r_update <= 1'b0;
    end else begin
      r_pend   <= w_pendNext;
      r_update <= w_grantHome | w_grantGuest;
      if (w_grantHome) begin
        r_homeScore <= w_homeUpOk ? r_homeScore + LP_ONE : r_homeScore - LP_ONE;
        r_ptr       <= 1'b0;
        r_lastTeam  <= 1'b0;
      end else if (w_grantGuest) begin
        r_guestScore <= w_guestUpOk ? r_guestScore + LP_ONE : r_guestScore - LP_ONE;
        r_ptr        <= 1'b1;
        r_lastTeam   <= 1'b1;
      end
    end
  end

  assign home_score_o  = r_homeScore;
  assign guest_score_o = r_guestScore;
  assign update_o      = r_update;
  assign last_team_o   = r_lastTeam;

endmodule

// File: tb/tb_scoreboard_ctrl.sv
// tb_scoreboard_ctrl: directed and randomized bench for scoreboard_ctrl against a rule-level model.
// Build with +define+SCORE_WIN_EN to also exercise the game-over feature.
module tb_scoreboard_ctrl;

  localparam int BW        = 7;
  localparam int MAX_SCORE = 99;
  localparam int WIN_SCORE = 21;
`ifdef SCORE_WIN_EN
  localparam int EXP_SAT = WIN_SCORE;
`else
  localparam int EXP_SAT = MAX_SCORE;
`endif

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          home_up_i = 1'b0;
  logic          home_down_i = 1'b0;
  logic          guest_up_i = 1'b0;
  logic          guest_down_i = 1'b0;
  logic          clear_i = 1'b0;
  logic [BW-1:0] home_score_o;
  logic [BW-1:0] guest_score_o;
  logic          update_o;
  logic          last_team_o;
`ifdef SCORE_WIN_EN
  logic          game_over_o;
`endif

  int nCompared = 0;
  int nMismatched = 0;
  int updSeen = 0;

  // Model state: sampled button history per clock edge plus the scoreboard rules.
  bit [3:0] samp [0:8191];
  int       cyc = 0;
  int       resetBase = 1;
  int       mHome = 0;
  int       mGuest = 0;
  bit [3:0] mPend = '0;
  bit       mPtr = 1'b0;
  bit       mUpd = 1'b0;
  bit       mLast = 1'b0;
  bit       mOver = 1'b0;

  scoreboard_ctrl #(.BW(BW), .MAX_SCORE(MAX_SCORE), .WIN_SCORE(WIN_SCORE)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .home_up_i    (home_up_i),
    .home_down_i  (home_down_i),
    .guest_up_i   (guest_up_i),
    .guest_down_i (guest_down_i),
    .clear_i      (clear_i),
    .home_score_o (home_score_o),
    .guest_score_o(guest_score_o),
    .update_o     (update_o),
`ifdef SCORE_WIN_EN
    .last_team_o  (last_team_o),
    .game_over_o  (game_over_o)
`else
    .last_team_o  (last_team_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    nCompared++;
    if (observed != expected) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  task automatic applyStimulus(input bit [3:0] btn, input bit clr);
    home_up_i    = btn[0];
    home_down_i  = btn[1];
    guest_up_i   = btn[2];
    guest_down_i = btn[3];
    clear_i      = clr;
  endtask

  function automatic bit sampAt(input int b, input int idx);
    if (idx < resetBase) return 1'b0;
    return samp[idx][b];
  endfunction

  function automatic void modelReset();
    mHome = 0; mGuest = 0; mPend = '0; mPtr = 0; mUpd = 0; mLast = 0; mOver = 0;
    resetBase = cyc + 1;
  endfunction

  // One clock edge of the scoreboard rules: a press counts two edges after it is first sampled.
  function automatic void modelEdge();
    bit [3:0] evt;
    int       delta [2];
    int       score;
    int       g;
    cyc++;
    for (int b = 0; b < 4; b++) evt[b] = sampAt(b, cyc - 2) && !sampAt(b, cyc - 3);
    if (clear_i) begin
      mHome = 0; mGuest = 0; mPend = '0; mPtr = 0; mUpd = 0; mOver = 0;
    end else if (mOver) begin
      mPend = '0; mUpd = 0;
    end else begin
      for (int t = 0; t < 2; t++) begin
        score = (t == 0) ? mHome : mGuest;
        if (mPend[2*t] && !mPend[2*t+1] && score < MAX_SCORE) delta[t] = 1;
        else if (mPend[2*t+1] && !mPend[2*t] && score > 0) delta[t] = -1;
        else delta[t] = 0;
      end
      if (delta[0] != 0 && delta[1] != 0) g = mPtr ? 0 : 1;
      else if (delta[0] != 0) g = 0;
      else if (delta[1] != 0) g = 1;
      else g = -1;
      for (int t = 0; t < 2; t++) begin
        if (delta[t] == 0 || g == t) begin
          mPend[2*t] = 1'b0;
          mPend[2*t+1] = 1'b0;
        end
      end
      mPend = mPend | evt;
      mUpd = (g >= 0);
      if (g == 0) mHome += delta[0];
      if (g == 1) mGuest += delta[1];
      if (g >= 0) begin
        mPtr = g[0];
        mLast = g[0];
`ifdef SCORE_WIN_EN
        if (delta[g] == 1 && ((g == 0) ? mHome : mGuest) == WIN_SCORE) mOver = 1;
`endif
      end
    end
    samp[cyc] = {guest_down_i, guest_up_i, home_down_i, home_up_i};
  endfunction

  task automatic compareAll();
    checkOutput("home_score", int'(home_score_o), mHome);
    checkOutput("guest_score", int'(guest_score_o), mGuest);
    checkOutput("update", int'(update_o), int'(mUpd));
    checkOutput("last_team", int'(last_team_o), int'(mLast));
`ifdef SCORE_WIN_EN
    checkOutput("game_over", int'(game_over_o), int'(mOver));
`endif
    if (update_o) updSeen++;
  endtask

  task automatic stepCycle();
    @(posedge clk_i);
    modelEdge();
    @(negedge clk_i);
    compareAll();
  endtask

  task automatic pressButtons(input bit [3:0] btn);
    applyStimulus(btn, 1'b0);
    stepCycle();
    applyStimulus(4'b0000, 1'b0);
    stepCycle();
  endtask

  task automatic settle(input int n);
    repeat (n) stepCycle();
  endtask

  initial begin
    bit [3:0] rndBtn;
    bit       rndClr;

    applyStimulus(4'b0000, 1'b0);
    rst_i = 1'b1;
    repeat (3) @(negedge clk_i);
    checkOutput("reset home", int'(home_score_o), 0);
    checkOutput("reset guest", int'(guest_score_o), 0);
    checkOutput("reset update", int'(update_o), 0);
    checkOutput("reset last_team", int'(last_team_o), 0);
    rst_i = 1'b0;
    modelReset();

    // Latency: held button counts once, three edges after first being sampled.
    applyStimulus(4'b0001, 1'b0);
    settle(3);
    checkOutput("lat before k+3", int'(home_score_o), 0);
    stepCycle();
    checkOutput("lat home at k+3", int'(home_score_o), 1);
    checkOutput("lat update at k+3", int'(update_o), 1);
    stepCycle();
    checkOutput("lat update drop", int'(update_o), 0);
    settle(5);
    applyStimulus(4'b0000, 1'b0);
    settle(4);
    checkOutput("lat held no repeat", int'(home_score_o), 1);

    // Async reset with no clock edge needed.
    repeat (4) pressButtons(4'b0001);
    settle(4);
    checkOutput("pre-reset home", int'(home_score_o), 5);
    #2 rst_i = 1'b1;
    #1;
    checkOutput("async reset home", int'(home_score_o), 0);
    checkOutput("async reset guest", int'(guest_score_o), 0);
    checkOutput("async reset update", int'(update_o), 0);
    modelReset();
    #1 rst_i = 1'b0;

    // Saturation at both ends.
    updSeen = 0;
    pressButtons(4'b1000);
    settle(4);
    checkOutput("down at zero guest", int'(guest_score_o), 0);
    checkOutput("down at zero updates", updSeen, 0);
    repeat (100) pressButtons(4'b0100);
    settle(4);
    checkOutput("sat guest", int'(guest_score_o), EXP_SAT);
    checkOutput("sat update count", updSeen, EXP_SAT);

    // Contention from 0/0 with the pointer at home: guest first.
    applyStimulus(4'b0000, 1'b1);
    stepCycle();
    applyStimulus(4'b0101, 1'b0);
    settle(3);
    checkOutput("cont k+2 home", int'(home_score_o), 0);
    checkOutput("cont k+2 guest", int'(guest_score_o), 0);
    stepCycle();
    checkOutput("cont first guest", int'(guest_score_o), 1);
    checkOutput("cont first home", int'(home_score_o), 0);
    checkOutput("cont first team", int'(last_team_o), 1);
    stepCycle();
    checkOutput("cont second home", int'(home_score_o), 1);
    checkOutput("cont second team", int'(last_team_o), 0);
    checkOutput("cont second update", int'(update_o), 1);
    applyStimulus(4'b0000, 1'b0);
    settle(4);

    // Cancel: up and down together on the same team.
    repeat (3) pressButtons(4'b0001);
    settle(4);
    checkOutput("cancel pre home", int'(home_score_o), 4);
    updSeen = 0;
    pressButtons(4'b0011);
    settle(6);
    checkOutput("cancel home", int'(home_score_o), 4);
    checkOutput("cancel updates", updSeen, 0);

    // Clear from 20.
    repeat (16) pressButtons(4'b0001);
    settle(4);
    checkOutput("clear pre home", int'(home_score_o), 20);
    applyStimulus(4'b0000, 1'b1);
    settle(2);
    applyStimulus(4'b0000, 1'b0);
    stepCycle();
    checkOutput("clear home", int'(home_score_o), 0);
    checkOutput("clear guest", int'(guest_score_o), 0);

    // Random button activity with occasional clears.
    rndBtn = '0;
    for (int i = 0; i < 2000; i++) begin
      for (int b = 0; b < 4; b++) if ($urandom_range(0, 3) == 0) rndBtn[b] = ~rndBtn[b];
      rndClr = ($urandom_range(0, 63) == 0);
      applyStimulus(rndBtn, rndClr);
      stepCycle();
    end
    applyStimulus(4'b0000, 1'b0);
    settle(6);

`ifdef SCORE_WIN_EN
    applyStimulus(4'b0000, 1'b1);
    stepCycle();
    applyStimulus(4'b0000, 1'b0);
    stepCycle();
    repeat (21) pressButtons(4'b0001);
    settle(4);
    checkOutput("win home", int'(home_score_o), WIN_SCORE);
    checkOutput("win game_over", int'(game_over_o), 1);
    pressButtons(4'b0100);
    settle(4);
    checkOutput("over guest frozen", int'(guest_score_o), 0);
    applyStimulus(4'b0000, 1'b1);
    stepCycle();
    applyStimulus(4'b0000, 1'b0);
    stepCycle();
    checkOutput("over cleared", int'(game_over_o), 0);
    checkOutput("over clear home", int'(home_score_o), 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
